// File: rtl/braid_mix_scheduler.sv
// Stage sequencer and concentration twin for a braided mixer network.
// Each stage holds all valves open for the dwell time, then averages FANOUT neighbouring channels.
module braid_mix_scheduler #(
   parameter int CHANNELS = 8,
   parameter int STAGES   = 16,
   parameter int FANOUT   = 2,
   parameter int CONC_W   = 8,
   parameter int DWELL_W  = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start_valid,
   output logic                            start_ready,
   input  logic [CHANNELS*CONC_W-1:0]      conc_in,
   input  logic [$clog2(STAGES+1)-1:0]     n_stages,
   input  logic [DWELL_W-1:0]              dwell,
   input  logic                            abort,
   output logic [CHANNELS-1:0]             mix_en,
   output logic [$clog2(STAGES)-1:0]       stage_idx,
   output logic                            busy,
   output logic                            done_valid,
   input  logic                            done_ready,
   output logic                            done_aborted,
   output logic [CHANNELS*CONC_W-1:0]      conc_out
);
   // state | meaning
   // IDLE  | waiting for a job, start_ready high
   // MIX   | valves open, dwell counter running, concentrations update per stage
   // DONE  | result held until done_ready

   localparam int NS_W  = $clog2(STAGES+1);
   localparam int SI_W  = $clog2(STAGES);
   localparam int LF    = $clog2(FANOUT);
   localparam int SUM_W = CONC_W + LF;

   typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

   state_t                     state;
   logic [CHANNELS*CONC_W-1:0] conc;
   logic [CHANNELS*CONC_W-1:0] conc_next;
   logic [NS_W-1:0]            n_cap;
   logic [NS_W-1:0]            n_clamped;
   logic [DWELL_W-1:0]         dwell_cap;
   logic [DWELL_W-1:0]         dwell_eff;
   logic [DWELL_W-1:0]         dwell_cnt;
   logic [SUM_W-1:0]           sum [CHANNELS];
   logic                       last_stage;

   assign conc_out   = conc;
   assign n_clamped  = (n_stages > NS_W'(STAGES)) ? NS_W'(STAGES) : n_stages;
   assign dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign last_stage = (NS_W'(stage_idx) == n_cap - NS_W'(1));

   // Round-half-up average of each channel and its FANOUT-1 successors, wrapping at the end
   always_comb begin
      conc_next = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sum[i] = SUM_W'(FANOUT/2);
         for (int k = 0; k < FANOUT; k++)
            sum[i] = sum[i] + SUM_W'(conc[((i+k) % CHANNELS)*CONC_W +: CONC_W]);
         conc_next[i*CONC_W +: CONC_W] = CONC_W'(sum[i] >> LF);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         conc         <= '0;
         n_cap        <= '0;
         dwell_cap    <= '0;
         dwell_cnt    <= '0;
         stage_idx    <= '0;
         mix_en       <= '0;
         busy         <= 1'b0;
         start_ready  <= 1'b1;
         done_valid   <= 1'b0;
         done_aborted <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  conc         <= conc_in;
                  n_cap        <= n_clamped;
                  dwell_cap    <= dwell_eff;
                  dwell_cnt    <= dwell_eff;
                  stage_idx    <= '0;
                  done_aborted <= 1'b0;
                  start_ready  <= 1'b0;
                  if (n_clamped == '0) begin
                     state      <= DONE;
                     done_valid <= 1'b1;
                  end else begin
                     state  <= MIX;
                     mix_en <= '1;
                     busy   <= 1'b1;
                  end
               end
            end
            MIX: begin
               // Abort wins over a coinciding stage update so the partial stage is dropped
               if (abort) begin
                  state        <= DONE;
                  mix_en       <= '0;
                  busy         <= 1'b0;
                  done_valid   <= 1'b1;
                  done_aborted <= 1'b1;
               end else if (dwell_cnt == DWELL_W'(1)) begin
                  conc <= conc_next;
                  if (last_stage) begin
                     state      <= DONE;
                     mix_en     <= '0;
                     busy       <= 1'b0;
                     done_valid <= 1'b1;
                  end else begin
                     stage_idx <= stage_idx + SI_W'(1);
                     dwell_cnt <= dwell_cap;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt - DWELL_W'(1);
               end
            end
            DONE: begin
               if (done_ready) begin
                  state       <= IDLE;
                  done_valid  <= 1'b0;
                  start_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_braid_mix_scheduler.sv
// Directed bench: a fanout-2 and a fanout-4 instance share stimulus; results are hand-computed.
module tb_braid_mix_scheduler;
   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic [63:0] conc_in;
   logic [4:0]  n_stages;
   logic [7:0]  dwell;
   logic        abort;
   logic        done_ready;

   logic        start_ready_a, busy_a, done_valid_a, done_aborted_a;
   logic [7:0]  mix_en_a;
   logic [3:0]  stage_idx_a;
   logic [63:0] conc_out_a;
   logic        start_ready_b, busy_b, done_valid_b, done_aborted_b;
   logic [7:0]  mix_en_b;
   logic [3:0]  stage_idx_b;
   logic [63:0] conc_out_b;

   int n_tests = 0;
   int n_fail  = 0;

   braid_mix_scheduler u_dut_f2 (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready_a),
      .conc_in(conc_in), .n_stages(n_stages), .dwell(dwell), .abort(abort),
      .mix_en(mix_en_a), .stage_idx(stage_idx_a), .busy(busy_a), .done_valid(done_valid_a),
      .done_ready(done_ready), .done_aborted(done_aborted_a), .conc_out(conc_out_a)
   );

   braid_mix_scheduler #(.FANOUT(4)) u_dut_f4 (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready_b),
      .conc_in(conc_in), .n_stages(n_stages), .dwell(dwell), .abort(abort),
      .mix_en(mix_en_b), .stage_idx(stage_idx_b), .busy(busy_b), .done_valid(done_valid_b),
      .done_ready(done_ready), .done_aborted(done_aborted_b), .conc_out(conc_out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // lat counts edges from the accepting edge (as 1) until done_valid is seen
   task automatic run_job(input logic [63:0] c, input int n, input int d,
                          output int mix_cycles, output int lat);
      conc_in     = c;
      n_stages    = 5'(n);
      dwell       = 8'(d);
      start_valid = 1'b1;
      mix_cycles  = 0;
      lat         = 0;
      do begin
         @(posedge clk); #1;
         start_valid = 1'b0;
         lat++;
         if (mix_en_a == 8'hFF) mix_cycles++;
      end while (!done_valid_a && lat < 2000);
      check("job_timeout", 64'(lat < 2000), 64'd1);
   endtask

   task automatic finish_job();
      done_ready = 1'b1;
      @(posedge clk); #1;
      done_ready = 1'b0;
      check("handshake_ready", 64'(start_ready_a), 64'd1);
      check("handshake_dv", 64'(done_valid_a), 64'd0);
   endtask

   int mc, lat, guard;
   logic stable;

   initial begin
      rst_n = 1'b0; start_valid = 1'b0; conc_in = '0; n_stages = '0;
      dwell = '0; abort = 1'b0; done_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_start_ready", 64'(start_ready_a), 64'd1);
      check("rst_mix_en", 64'(mix_en_a), 64'd0);
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_done_valid", 64'(done_valid_a), 64'd0);
      check("rst_conc", conc_out_a, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single stage, impulse on ch0
      run_job(64'h0000_0000_0000_00FF, 1, 3, mc, lat);
      check("t1_mix_cycles", 64'(mc), 64'd3);
      check("t1_latency", 64'(lat), 64'd4);
      check("t1_conc_f2", conc_out_a, 64'h8000_0000_0000_0080);
      check("t1_conc_f4", conc_out_b, 64'h4040_4000_0000_0040);
      check("t1_aborted", 64'(done_aborted_a), 64'd0);
      finish_job();

      // abort in IDLE has no effect
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("idle_abort_ready", 64'(start_ready_a), 64'd1);
      check("idle_abort_dv", 64'(done_valid_a), 64'd0);

      // uniform input, full depth, dwell 0 treated as 1
      run_job(64'h6464_6464_6464_6464, 16, 0, mc, lat);
      check("t2_mix_cycles", 64'(mc), 64'd16);
      check("t2_latency", 64'(lat), 64'd17);
      check("t2_conc_f2", conc_out_a, 64'h6464_6464_6464_6464);
      check("t2_conc_f4", conc_out_b, 64'h6464_6464_6464_6464);
      check("t2_stage_idx", 64'(stage_idx_a), 64'd15);
      check("t2_aborted", 64'(done_aborted_a), 64'd0);
      finish_job();

      // stage count clamped to 16
      run_job(64'h6464_6464_6464_6464, 20, 2, mc, lat);
      check("t3_mix_cycles", 64'(mc), 64'd32);
      check("t3_latency", 64'(lat), 64'd33);
      finish_job();

      // zero stages passes input straight through
      run_job(64'h0123_4567_89AB_CDEF, 0, 5, mc, lat);
      check("t4_mix_cycles", 64'(mc), 64'd0);
      check("t4_latency", 64'(lat), 64'd1);
      check("t4_conc", conc_out_a, 64'h0123_4567_89AB_CDEF);
      finish_job();

      // abort during the third stage of a 5-stage job
      conc_in = 64'h0000_0000_0000_00FF; n_stages = 5'd5; dwell = 8'd4;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      guard = 0;
      while (stage_idx_a != 4'd2 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("t5_reach_stage2", 64'(guard < 200), 64'd1);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("t5_mix_en", 64'(mix_en_a), 64'd0);
      check("t5_done_valid", 64'(done_valid_a), 64'd1);
      check("t5_aborted", 64'(done_aborted_a), 64'd1);
      check("t5_conc_f2", conc_out_a, 64'h8040_0000_0000_0040);
      check("t5_conc_f4", conc_out_b, 64'h2030_4030_2010_0010);
      finish_job();

      // fanout-4 result, then hold done_ready low with start_valid pounding
      run_job(64'h0000_0000_0000_00C8, 1, 1, mc, lat);
      check("t6_conc_f4", conc_out_b, 64'h3232_3200_0000_0032);
      check("t6_conc_f2", conc_out_a, 64'h6400_0000_0000_0064);
      stable = 1'b1;
      start_valid = 1'b1;
      conc_in = 64'h1111_1111_1111_1111;
      n_stages = 5'd3;
      repeat (10) begin
         @(posedge clk); #1;
         if (done_valid_b !== 1'b1 || conc_out_b !== 64'h3232_3200_0000_0032 ||
             start_ready_b !== 1'b0 || mix_en_b !== 8'h00) stable = 1'b0;
      end
      start_valid = 1'b0;
      check("t6_hold_stable", 64'(stable), 64'd1);
      finish_job();

      // asynchronous reset in the middle of a job
      conc_in = 64'h0000_0000_0000_00FF; n_stages = 5'd16; dwell = 8'd2;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      check("t7_pre_busy", 64'(busy_a), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t7_rst_mix_en", 64'(mix_en_a), 64'd0);
      check("t7_rst_busy", 64'(busy_a), 64'd0);
      check("t7_rst_stage", 64'(stage_idx_a), 64'd0);
      check("t7_rst_dv", 64'(done_valid_a), 64'd0);
      check("t7_rst_conc", conc_out_a, 64'd0);
      check("t7_rst_ready", 64'(start_ready_a), 64'd1);
      #10;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t7_after_ready", 64'(start_ready_a), 64'd1);
      run_job(64'h0000_0000_0000_00FF, 1, 3, mc, lat);
      check("t7_fresh_latency", 64'(lat), 64'd4);
      check("t7_fresh_conc", conc_out_a, 64'h8000_0000_0000_0080);
      finish_job();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/braid_mix_scheduler.md
# braid_mix_scheduler

Parametrised sequencer and digital twin for an N-channel braided mixer network. It accepts a stage count, a per-stage dwell time and the initial reagent concentration on every channel. It then drives the mixer-enable valves one stage at a time and holds each stage for the dwell time. In parallel it computes the predicted concentration on every channel after each stage. It sits between the protocol controller (start/done handshakes) and the valve driver, generalising the fixed 8×16 fanout-2 braid to configurable channel count, depth and fanout, with runtime stage count and abort.

## Interface
- CHANNELS, 8, number of braid channels (≥2)
- STAGES, 16, maximum number of mixing stages
- FANOUT, 2, inputs per mixer; power of two, 2 ≤ FANOUT ≤ CHANNELS
- CONC_W, 8, concentration width per channel (unsigned fixed point)
- DWELL_W, 8, dwell counter width
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- start_valid  in  1  job request
- start_ready  out  1  high in IDLE only
- conc_in  in  CHANNELS*CONC_W  initial concentrations; channel i at bits [i*CONC_W +: CONC_W]
- n_stages  in  $clog2(STAGES+1)  stages to run; values > STAGES are clamped to STAGES
- dwell  in  DWELL_W  cycles per stage; 0 is treated as 1
- abort  in  1  terminate the running job
- mix_en  out  CHANNELS  valve enables for the active stage
- stage_idx  out  $clog2(STAGES)  stage currently mixing
- busy  out  1  high in MIX
- done_valid  out  1  result available
- done_ready  in  1  result consumed
- done_aborted  out  1  job ended by abort; valid with done_valid
- conc_out  out  CHANNELS*CONC_W  predicted concentrations; valid with done_valid

## Operation
- States: IDLE, MIX, DONE. Reset puts the block in IDLE and clears all registers.
- Reset output values: start_ready=1, mix_en=0, stage_idx=0, busy=0, done_valid=0, done_aborted=0, conc_out=0.
- IDLE:
  - On start_valid && start_ready, capture conc_in, the clamped n_stages, and max(dwell,1). Clear stage_idx and done_aborted.
  - If the captured n_stages==0, go to DONE with conc_out equal to conc_in. Otherwise go to MIX.
- MIX:
  - mix_en = all ones. busy=1. The dwell counter loads the captured dwell value and decrements each cycle.
  - On the last dwell cycle (counter==1), every channel i updates: c[i] ← (Σ_{k=0..FANOUT-1} c[(i+k) mod CHANNELS] + FANOUT/2) >> log2(FANOUT). This is round-half-up. The sum is held in CONC_W+log2(FANOUT) bits, so it cannot overflow.
  - All channels update simultaneously from the old values.
  - If stage_idx == n_stages-1, go to DONE. Otherwise increment stage_idx and reload the dwell counter.
- abort in MIX: go to DONE on the next edge with done_aborted=1. conc_out holds the value after the last completed stage; the partial stage is discarded. mix_en drops the same edge.
- abort in IDLE or DONE: ignored.
- DONE: done_valid=1. conc_out and done_aborted are stable. On done_valid && done_ready, go to IDLE.
- start_valid outside IDLE is ignored and is not queued.
- Wrap-around: mixer inputs index channels modulo CHANNELS. The last channel mixes with channel 0..FANOUT-2.

## Timing
- Start is accepted at edge T. MIX is entered at T+1, and mix_en is high from T+1.
- mix_en stays high for exactly n_stages × max(dwell,1) cycles.
- done_valid rises on the cycle after the final dwell cycle. Latency from accept to done_valid is n_stages×max(dwell,1)+1 cycles.
- With n_stages==0, done_valid rises at T+1.
- stage_idx changes on the same edge as the concentration update.
- done_ready is sampled while done_valid=1. The earliest new accept is the cycle after the handshake.
- Asynchronous reset mid-job: all outputs go to their reset values immediately, with no done pulse.

## Test plan
- Fanout-2, 1 stage, dwell=3; conc_in ch0=255, others 0 -> mix_en=0xFF for 3 cycles; done at T+4; ch0=128, ch7=128, all others 0.
- Uniform conc_in 100 on all channels, n_stages=16, dwell=0 -> 16 mix cycles; conc_out all 100; done_aborted=0.
- n_stages=20 with STAGES=16 -> clamped to 16 stages (16×dwell cycles); n_stages=0 -> done at T+1 with conc_out==conc_in and mix_en never high.
- abort asserted in stage 2 (third stage) of a 5-stage job, dwell=4 -> mix_en low next edge; done_aborted=1; conc_out equals the 2-stage result.
- FANOUT=4, CHANNELS=8; ch0=200, others 0, 1 stage -> ch0, ch5, ch6, ch7 = 50; others 0. Then hold done_ready low for 10 cycles -> done_valid and conc_out stable; start_valid is ignored throughout.
- Assert rst_n low mid-MIX -> outputs go to reset values asynchronously; after release, start_ready=1 and a fresh job completes correctly.
